// File: rtl/moore_seq_pkg.sv
// Shared definitions for the moore_seq step sequencer: width helper,
// direction encoding and default sizing.
package moore_seq_pkg;

  localparam int DEF_NUM_STATES = 4;
  localparam int DEF_STEP       = 5;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/moore_seq_if.sv
// Control/status bundle between the sequencer and its user.
// master: drives controls, observes state; slave: the sequencer itself.
interface moore_seq_if #(
  parameter int SW = 2
);
  logic          en;
  logic          dir;
  logic          load;
  logic [SW-1:0] load_state;
  logic [SW-1:0] state;
  logic          term;
  logic          adv;
  logic          wrap;

  modport master (
    output en, dir, load, load_state,
    input  state, term, adv, wrap
  );

  modport slave (
    input  en, dir, load, load_state,
    output state, term, adv, wrap
  );
endinterface

// File: rtl/moore_seq_prescaler.sv
// Dwell prescaler: counts 0..STEP while enabled and emits tick on the
// cycle the count sits at STEP, wrapping back to zero on that edge.
module moore_seq_prescaler #(
  parameter int STEP  = 5,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_W'(STEP));

  // Count register; clear wins over counting, disable freezes the count.
  always_ff @(posedge clk) begin
    if (rst)        cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en)    cnt <= tick ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/moore_seq.sv
// Moore step sequencer: walks state through 0..NUM_STATES-1, dwelling
// STEP+1 enabled cycles per state, with load and direction control.
// Optional feature: define MOORE_SEQ_PINGPONG_EN to make the sequence
// bounce between the end states instead of wrapping modulo NUM_STATES.
module moore_seq
  import moore_seq_pkg::*;
#(
  parameter int NUM_STATES = DEF_NUM_STATES,
  parameter int STEP       = DEF_STEP,
  parameter int CNT_W      = 5,
  parameter int SW         = clog2(NUM_STATES)
) (
  input  logic        clk,
  input  logic        rst,
  moore_seq_if.slave  bus
);

  localparam logic [SW-1:0] LAST = SW'(NUM_STATES - 1);

  logic          tick;
  logic [SW-1:0] state_q, state_d;
  logic          adv_q, adv_d;
  logic          wrap_q, wrap_d;
  logic          load_ok;

  moore_seq_prescaler #(
    .STEP  (STEP),
    .CNT_W (CNT_W)
  ) u_pre (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .clear (bus.load),
    .tick  (tick)
  );

  // Out-of-range load values fall back to state 0.
  assign load_ok = int'(bus.load_state) < NUM_STATES;

`ifdef MOORE_SEQ_PINGPONG_EN
  dir_e          dir_q, dir_d;
  logic          going_up;
  logic [SW-1:0] nxt;

  // Bounce target: turn around at either end, even if a load parked us
  // at the top while still heading up.
  always_comb begin
    going_up = (dir_q == DIR_UP) ? (state_q != LAST) : (state_q == '0);
    nxt      = going_up ? state_q + SW'(1) : state_q - SW'(1);
  end

  // Next state, turn direction and pulses.
  always_comb begin
    state_d = state_q;
    adv_d   = 1'b0;
    wrap_d  = 1'b0;
    dir_d   = dir_q;
    if (bus.load) begin
      state_d = load_ok ? bus.load_state : '0;
      dir_d   = DIR_UP;
    end else if (tick) begin
      state_d = nxt;
      adv_d   = 1'b1;
      wrap_d  = (nxt == LAST) || (nxt == '0);
      if (nxt == LAST)    dir_d = DIR_DOWN;
      else if (nxt == '0) dir_d = DIR_UP;
      else                dir_d = going_up ? DIR_UP : DIR_DOWN;
    end
  end

  // Direction register for the bounce.
  always_ff @(posedge clk) begin
    if (rst) dir_q <= DIR_UP;
    else     dir_q <= dir_d;
  end
`else
  // Next state and pulses; direction taken live from the dir input.
  always_comb begin
    state_d = state_q;
    adv_d   = 1'b0;
    wrap_d  = 1'b0;
    if (bus.load) begin
      state_d = load_ok ? bus.load_state : '0;
    end else if (tick) begin
      adv_d = 1'b1;
      if (bus.dir == DIR_UP) begin
        wrap_d  = (state_q == LAST);
        state_d = (state_q == LAST) ? '0 : state_q + SW'(1);
      end else begin
        wrap_d  = (state_q == '0);
        state_d = (state_q == '0) ? LAST : state_q - SW'(1);
      end
    end
  end
`endif

  // State and pulse registers; pulses line up with the new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      adv_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adv_q   <= adv_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.state = state_q;
  assign bus.term  = (state_q == LAST);
  assign bus.adv   = adv_q;
  assign bus.wrap  = wrap_q;

endmodule
